kt_tour_sequencer: RTL and testbench

Synthesizable, parametrised host-side sequencer that drives RemoteComm's command handshake (cmd/snd_cmd/cmd_snt/resp_rdy/resp) to run a gyro calibration followed by one or many Knight's Tours.
It generalises the single-start calibrate-then-tour procedure in three ways: configurable board dimension, a sweep mode covering every start square, and per-phase timeouts with coded failure reporting.
It sits beside RemoteComm in on-board self-test and in full-chip benches.

---
 rtl/kt_seq_pkg.sv | 29 ++
 rtl/kt_seq_timer.sv | 29 ++
 rtl/kt_tour_sequencer.sv | 178 +++++++++++++++++
 tb/tb_kt_tour_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/kt_seq_pkg.sv
// Shared types and command constants for the Knight's Tour sequencer.
package kt_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CAL_SEND  = 4'd1,
    S_CAL_WSNT  = 4'd2,
    S_CAL_WRSP  = 4'd3,
    S_TOUR_SEND = 4'd4,
    S_TOUR_WSNT = 4'd5,
    S_TOUR_WRSP = 4'd6,
    S_ADVANCE   = 4'd7,
    S_DONE      = 4'd8
  } seq_state_t;

  typedef enum logic [2:0] {
    FAIL_NONE      = 3'd0,
    FAIL_SNT_TO    = 3'd1,
    FAIL_CAL_TO    = 3'd2,
    FAIL_TOUR_TO   = 3'd3,
    FAIL_BAD_ACK   = 3'd4,
    FAIL_BAD_COORD = 3'd5
  } fail_code_t;

  localparam logic [15:0] CMD_CAL     = 16'h2000;
  localparam logic [3:0]  CMD_TOUR_OP = 4'h6;
  localparam logic [7:0]  POS_ACK     = 8'hA5;

endpackage

// File: rtl/kt_seq_timer.sv
// Clear/enable up-counter; expired flags the last allowed cycle before a timeout.
module kt_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end
  end

  assign expired = en && (count == limit - ONE);

endmodule

// File: rtl/kt_tour_sequencer.sv
// Drives RemoteComm through a gyro calibration and then one or every Knight's Tour start square.
module kt_tour_sequencer
  import kt_seq_pkg::*;
#(
  parameter int BOARD_DIM    = 5,
  parameter int SNT_TIMEOUT  = 100000,
  parameter int CAL_TIMEOUT  = 1000000,
  parameter int TOUR_TIMEOUT = 60000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        sweep,
  input  logic [3:0]  start_x,
  input  logic [3:0]  start_y,
  output logic [15:0] cmd,
  output logic        snd_cmd,
  input  logic        cmd_snt,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code,
  output logic [3:0]  cur_x,
  output logic [3:0]  cur_y,
  output logic [7:0]  tours_ok
);

  localparam int TW = $clog2(TOUR_TIMEOUT + 1);
  localparam logic [TW-1:0] SNT_LIM  = TW'(SNT_TIMEOUT);
  localparam logic [TW-1:0] CAL_LIM  = TW'(CAL_TIMEOUT);
  localparam logic [TW-1:0] TOUR_LIM = TW'(TOUR_TIMEOUT);
  localparam logic [3:0]    LAST     = 4'(BOARD_DIM - 1);

  seq_state_t state, nxt;
  fail_code_t fail_q, fail_val;
  logic       fail_set;
  logic       sweep_q;
  logic       waiting, expired, timer_clr, begin_seq;
  logic [TW-1:0] limit;
  logic [3:0] adv_x, adv_y;

  assign waiting   = (state == S_CAL_WSNT) || (state == S_CAL_WRSP) ||
                     (state == S_TOUR_WSNT) || (state == S_TOUR_WRSP);
  assign timer_clr = !waiting || (nxt != state);
  assign begin_seq = !abort && start && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    case (state)
      S_CAL_WRSP:  limit = CAL_LIM;
      S_TOUR_WRSP: limit = TOUR_LIM;
      default:     limit = SNT_LIM;
    endcase
  end

  kt_seq_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clr),
    .en      (waiting),
    .limit   (limit),
    .expired (expired)
  );

  // Sweep order: y runs fastest, wrapping into the next x column.
  always_comb begin
    if (cur_y == LAST) begin
      adv_x = cur_x + 4'd1;
      adv_y = 4'd0;
    end else begin
      adv_x = cur_x;
      adv_y = cur_y + 4'd1;
    end
  end

  // Qualifying events are tested before expired, so an event on the last cycle wins.
  always_comb begin
    nxt      = state;
    fail_set = 1'b0;
    fail_val = FAIL_NONE;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (!sweep && ((start_x > LAST) || (start_y > LAST))) begin
              nxt      = S_DONE;
              fail_set = 1'b1;
              fail_val = FAIL_BAD_COORD;
            end else begin
              nxt = S_CAL_SEND;
            end
          end
        end
        S_CAL_SEND:  nxt = S_CAL_WSNT;
        S_TOUR_SEND: nxt = S_TOUR_WSNT;
        S_CAL_WSNT, S_TOUR_WSNT: begin
          if (cmd_snt) begin
            nxt = (state == S_CAL_WSNT) ? S_CAL_WRSP : S_TOUR_WRSP;
          end else if (expired) begin
            nxt      = S_DONE;
            fail_set = 1'b1;
            fail_val = FAIL_SNT_TO;
          end
        end
        S_CAL_WRSP, S_TOUR_WRSP: begin
          if (resp_rdy) begin
            if (resp == POS_ACK) begin
              nxt = (state == S_CAL_WRSP) ? S_TOUR_SEND : S_ADVANCE;
            end else begin
              nxt      = S_DONE;
              fail_set = 1'b1;
              fail_val = FAIL_BAD_ACK;
            end
          end else if (expired) begin
            nxt      = S_DONE;
            fail_set = 1'b1;
            fail_val = (state == S_CAL_WRSP) ? FAIL_CAL_TO : FAIL_TOUR_TO;
          end
        end
        S_ADVANCE: begin
          if (!sweep_q || ((cur_x == LAST) && (cur_y == LAST))) begin
            nxt = S_DONE;
          end else begin
            nxt = S_TOUR_SEND;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fail_q   <= FAIL_NONE;
      sweep_q  <= 1'b0;
      cur_x    <= 4'd0;
      cur_y    <= 4'd0;
      tours_ok <= 8'd0;
      cmd      <= 16'h0000;
    end else begin
      state <= nxt;
      if (begin_seq) begin
        fail_q   <= fail_val;
        tours_ok <= 8'd0;
        sweep_q  <= sweep;
        cur_x    <= sweep ? 4'd0 : start_x;
        cur_y    <= sweep ? 4'd0 : start_y;
      end else if (fail_set) begin
        fail_q <= fail_val;
      end
      if ((state == S_TOUR_WRSP) && (nxt == S_ADVANCE) && (tours_ok != 8'hFF)) begin
        tours_ok <= tours_ok + 8'd1;
      end
      if ((state == S_ADVANCE) && (nxt == S_TOUR_SEND)) begin
        cur_x <= adv_x;
        cur_y <= adv_y;
      end
      if (nxt == S_CAL_SEND) begin
        cmd <= CMD_CAL;
      end else if (nxt == S_TOUR_SEND) begin
        cmd <= (state == S_ADVANCE) ? {CMD_TOUR_OP, 4'h0, adv_x, adv_y}
                                    : {CMD_TOUR_OP, 4'h0, cur_x, cur_y};
      end
    end
  end

  assign snd_cmd   = ((state == S_CAL_SEND) || (state == S_TOUR_SEND)) && !abort;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign pass      = done && (fail_q == FAIL_NONE);
  assign fail_code = fail_q;

endmodule

// File: tb/tb_kt_tour_sequencer.sv
// Randomised scoreboard bench for kt_tour_sequencer with a RemoteComm responder model.
`timescale 1ns/1ps
module tb_kt_tour_sequencer;

  localparam int D    = 4;
  localparam int SNT  = 40;
  localparam int CAL  = 50;
  localparam int TOUR = 60;

  // clock / reset and DUT
  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, abort_run, abort_rsp, sweep;
  logic [3:0]  start_x, start_y;
  logic [15:0] cmd;
  logic        snd_cmd, cmd_snt, resp_rdy;
  logic [7:0]  resp;
  logic        busy, done, pass;
  logic [2:0]  fail_code;
  logic [3:0]  cur_x, cur_y;
  logic [7:0]  tours_ok;

  always #5 clk = ~clk;
  assign abort = abort_run | abort_rsp;

  kt_tour_sequencer #(
    .BOARD_DIM(D), .SNT_TIMEOUT(SNT), .CAL_TIMEOUT(CAL), .TOUR_TIMEOUT(TOUR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sweep(sweep),
    .start_x(start_x), .start_y(start_y), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
    .done(done), .pass(pass), .fail_code(fail_code), .cur_x(cur_x),
    .cur_y(cur_y), .tours_ok(tours_ok)
  );

  // per-command responder plan, indexed by command number within a sequence
  int         p_snt [0:31];
  int         p_rsp [0:31];
  logic [7:0] p_val [0:31];
  int         abort_k;
  int         rsp_count;
  int         run_base;
  logic       rsp_busy;

  logic [15:0] exp_cmd_q[$];
  logic [19:0] exp_res_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RemoteComm model: delays are counted in cycles after the previous handshake event
  initial begin
    int k;
    cmd_snt = 1'b0; resp_rdy = 1'b0; resp = 8'h00; abort_rsp = 1'b0;
    rsp_busy = 1'b0; rsp_count = 0;
    forever begin
      @(negedge clk);
      while (snd_cmd === 1'b1 && !rst) begin
        rsp_busy = 1'b1;
        k = rsp_count - run_base;
        rsp_count++;
        repeat (1 + p_snt[k]) @(negedge clk);
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
        repeat (p_rsp[k]) @(negedge clk);
        resp_rdy  = 1'b1;
        resp      = p_val[k];
        abort_rsp = (k == abort_k);
        @(negedge clk);
        resp_rdy = 1'b0; resp = 8'h00; abort_rsp = 1'b0;
      end
      rsp_busy = 1'b0;
    end
  end

  // monitor: compares every send pulse and every completed sequence
  initial begin
    logic        done_q;
    logic [15:0] e;
    logic [19:0] r;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (snd_cmd) begin
          if (exp_cmd_q.size() == 0) begin
            check("cmd_unexpected", {16'h0, cmd}, 32'hFFFF_FFFF);
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd", {16'h0, cmd}, {16'h0, e});
          end
        end
        if (done && !done_q) begin
          if (exp_res_q.size() == 0) begin
            check("result_unexpected", {12'h0, fail_code, pass, tours_ok, cur_x, cur_y}, 32'hFFFF_FFFF);
          end else begin
            r = exp_res_q.pop_front();
            check("result", {12'h0, fail_code, pass, tours_ok, cur_x, cur_y}, {12'h0, r});
          end
        end
      end
      done_q = done;
    end
  end

  // reference model: walk the square list and decide each command's fate from the plan
  task automatic model_seq(input logic sw, input int sx, input int sy,
                           output logic aborted, output logic [19:0] res);
    int fc, ok, x, y, n, lim;
    aborted = 1'b0; fc = 0; ok = 0;
    if (!sw && (sx >= D || sy >= D)) begin
      x = sx; y = sy; fc = 5;
    end else begin
      x = sw ? 0 : sx;
      y = sw ? 0 : sy;
      n = sw ? D * D : 1;
      exp_cmd_q.push_back(16'h2000);
      if (p_snt[0] >= SNT) fc = 1;
      else if (p_rsp[0] >= CAL) fc = 2;
      else if (p_val[0] != 8'hA5) fc = 4;
      for (int s = 0; s < n && fc == 0 && !aborted; s++) begin
        if (sw) begin x = s / D; y = s % D; end
        exp_cmd_q.push_back({4'h6, 4'h0, x[3:0], y[3:0]});
        lim = TOUR;
        if (p_snt[s+1] >= SNT) fc = 1;
        else if (s + 1 == abort_k) aborted = 1'b1;
        else if (p_rsp[s+1] >= lim) fc = 3;
        else if (p_val[s+1] != 8'hA5) fc = 4;
        else ok++;
      end
    end
    res = {fc[2:0], (fc == 0), ok[7:0], x[3:0], y[3:0]};
  endtask

  task automatic plan_ok();
    for (int k = 0; k < 32; k++) begin
      p_snt[k] = $urandom_range(0, 3);
      p_rsp[k] = $urandom_range(0, 4);
      p_val[k] = 8'hA5;
    end
    abort_k = -1;
  endtask

  task automatic plan_random();
    for (int k = 0; k < 32; k++) begin
      p_snt[k] = ($urandom_range(0, 19) == 0) ? SNT - 1 + $urandom_range(0, 1) : $urandom_range(0, 3);
      p_rsp[k] = ($urandom_range(0, 19) == 0) ? ((k == 0) ? CAL : TOUR) - 1 + $urandom_range(0, 1)
                                              : $urandom_range(0, 6);
      p_val[k] = ($urandom_range(0, 29) == 0) ? 8'h5A : 8'hA5;
    end
    abort_k = -1;
  endtask

  // driver: idle the DUT, predict, start, then wait (bounded) for the sequence to settle
  task automatic run_seq(input logic sw, input int sx, input int sy);
    logic        ab;
    logic [19:0] res;
    int          cyc;
    @(negedge clk); abort_run = 1'b1;
    @(negedge clk); abort_run = 1'b0;
    model_seq(sw, sx, sy, ab, res);
    if (!ab) exp_res_q.push_back(res);
    run_base = rsp_count;
    sweep = sw; start_x = sx[3:0]; start_y = sy[3:0]; start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!((ab ? !busy : done) && !rsp_busy) && cyc < 6000) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    check("settle_in_time", {31'h0, (cyc < 6000)}, 32'h1);
    check("cmds_all_seen", exp_cmd_q.size(), 0);
    check("busy_after", {31'h0, busy}, 32'h0);
    if (ab) begin
      check("abort_done", {31'h0, done}, 32'h0);
      check("abort_tours_ok", {24'h0, tours_ok}, {24'h0, res[15:8]});
      check("abort_cur", {24'h0, cur_x, cur_y}, {24'h0, res[7:0]});
    end else begin
      check("result_seen", exp_res_q.size(), 0);
    end
    exp_cmd_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort_run = 1'b0; sweep = 1'b0;
    start_x = 4'd0; start_y = 4'd0; run_base = 0;
    plan_ok();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd", {16'h0, cmd}, 32'h0);
    check("reset_flags", {28'h0, snd_cmd, busy, done, pass}, 32'h0);
    check("reset_fail_code", {29'h0, fail_code}, 32'h0);
    check("reset_cur", {24'h0, cur_x, cur_y}, 32'h0);
    check("reset_tours_ok", {24'h0, tours_ok}, 32'h0);

    // single square, full success
    plan_ok(); run_seq(1'b0, 0, 0);
    // sweep of the whole board
    plan_ok(); run_seq(1'b1, 0, 0);
    // bad tour acknowledge
    plan_ok(); p_val[1] = 8'h5A; run_seq(1'b0, 2, 3);
    // calibration response boundary
    plan_ok(); p_rsp[0] = CAL - 1; run_seq(1'b0, 1, 1);
    plan_ok(); p_rsp[0] = CAL;     run_seq(1'b0, 1, 1);
    // send-complete boundary and tour response boundary
    plan_ok(); p_snt[0] = SNT - 1; run_seq(1'b0, 3, 0);
    plan_ok(); p_snt[1] = SNT;     run_seq(1'b0, 3, 0);
    plan_ok(); p_rsp[1] = TOUR - 1; run_seq(1'b0, 0, 3);
    plan_ok(); p_rsp[3] = TOUR;     run_seq(1'b1, 0, 0);
    // coordinates off the board
    plan_ok(); run_seq(1'b0, D, 0);
    plan_ok(); run_seq(1'b0, 1, 9);
    // abort coincident with the response for square (1,2)
    plan_ok(); abort_k = 1 + 1 * D + 2; run_seq(1'b1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      plan_random();
      run_seq(($urandom_range(0, 2) == 0), $urandom_range(0, D), $urandom_range(0, D));
    end

    // asynchronous reset while waiting for cmd_snt of the calibration
    plan_ok(); p_snt[0] = 30;
    @(negedge clk); abort_run = 1'b1;
    @(negedge clk); abort_run = 1'b0;
    exp_cmd_q.push_back(16'h2000);
    run_base = rsp_count;
    sweep = 1'b0; start_x = 4'd1; start_y = 4'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("rst_cmd", {16'h0, cmd}, 32'h0);
    check("rst_flags", {28'h0, snd_cmd, busy, done, pass}, 32'h0);
    check("rst_fail_cur_ok", {13'h0, fail_code, cur_x, cur_y, tours_ok}, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 500 && rsp_busy; c++) @(negedge clk);
    check("rst_cmds_seen", exp_cmd_q.size(), 0);
    exp_cmd_q.delete();
    plan_ok(); run_seq(1'b0, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
